// File: rtl/mem_wb_unit.sv
// Memory-access / write-back stage: runs loads and stores over a req/ack port,
// extends load data and drives the register-file write port.
module mem_wb_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   output logic        ready,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        RegWrite_in,
   input  logic [31:0] alu_result,
   input  logic [31:0] rs2_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        RegWrite,
   output logic [4:0]  rd_out,
   output logic [31:0] write_data,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WB, S_DONE, S_ERR} state_t;

   typedef struct packed {
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        ld;
      logic        st;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] sdata;
   } instr_t;

   state_t           state, nxt;
   instr_t           iq;
   logic [31:0]      wb_q;
   logic [CNT_W-1:0] cnt;

   // 0 = byte, 1 = half, 2 = word; stores only know SB/SH, everything else is a word
   function automatic logic [1:0] size_of(input logic [2:0] f3, input logic st);
      if (st) return (f3 == 3'b000) ? 2'd0 : (f3 == 3'b001) ? 2'd1 : 2'd2;
      else    return (f3[1:0] == 2'b00) ? 2'd0 : (f3[1:0] == 2'b01) ? 2'd1 : 2'd2;
   endfunction

   logic       in_mem, in_st, in_mis;
   logic [1:0] in_sz;

   always_comb begin
      in_mem = MemRead | MemWrite;
      in_st  = MemWrite;
      in_sz  = size_of(funct3, in_st);
      in_mis = ((in_sz == 2'd1) & alu_result[0]) | ((in_sz == 2'd2) & (|alu_result[1:0]));
   end

   logic [1:0]  sz_q, a_q;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;
   logic        sgn;

   always_comb begin
      sz_q    = size_of(iq.f3, iq.st);
      a_q     = iq.addr[1:0];
      sgn     = ~iq.f3[2];
      ld_byte = mem_rdata[{a_q, 3'b000} +: 8];
      ld_half = mem_rdata[{a_q[1], 4'b0000} +: 16];
      case (sz_q)
         2'd0:    ld_ext = {{24{sgn & ld_byte[7]}}, ld_byte};
         2'd1:    ld_ext = {{16{sgn & ld_half[15]}}, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: if (valid) nxt = in_mem ? (in_mis ? S_ERR : S_REQ) : S_WB;
         S_REQ: begin
            if (mem_ack)                             nxt = iq.ld ? S_WB : S_DONE;
            else if (cnt == CNT_W'(TIMEOUT - 1))     nxt = S_ERR;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         iq    <= '0;
         wb_q  <= '0;
      end else begin
         state <= nxt;
         cnt   <= (state == S_REQ && nxt == S_REQ) ? cnt + 1'b1 : '0;
         if (state == S_IDLE && valid) begin
            // both MemRead and MemWrite set is a store with no write-back
            iq   <= '{f3: funct3, rd: rd, ld: MemRead & ~MemWrite, st: MemWrite,
                      rw: RegWrite_in, addr: alu_result, sdata: rs2_data};
            wb_q <= alu_result;
         end
         if (state == S_REQ && mem_ack && iq.ld) wb_q <= ld_ext;
      end
   end

   always_comb begin
      ready      = (state == S_IDLE);
      mem_req    = (state == S_REQ);
      mem_we     = mem_req & iq.st;
      mem_addr   = mem_req ? {iq.addr[31:2], 2'b00} : '0;
      mem_be     = '0;
      mem_wdata  = '0;
      if (mem_req) begin
         case (sz_q)
            2'd0:    begin mem_be = 4'b0001 << a_q; mem_wdata = {4{iq.sdata[7:0]}};  end
            2'd1:    begin mem_be = 4'b0011 << a_q; mem_wdata = {2{iq.sdata[15:0]}}; end
            default: begin mem_be = 4'b1111;        mem_wdata = iq.sdata;            end
         endcase
      end
      RegWrite   = (state == S_WB) & iq.rw & (iq.rd != 5'd0);
      rd_out     = (state == S_WB) ? iq.rd : '0;
      write_data = (state == S_WB) ? wb_q : '0;
      done       = (state == S_WB) | (state == S_DONE);
      err        = (state == S_ERR);
   end

endmodule

// File: tb/tb_mem_wb_unit.sv
// Randomized scoreboard bench for mem_wb_unit with a responding memory model.
module tb_mem_wb_unit;
   logic        clk = 0, rst = 0;
   logic        valid, ready, MemRead, MemWrite, RegWrite_in;
   logic [2:0]  funct3;
   logic [4:0]  rd, rd_out;
   logic [31:0] alu_result, rs2_data, mem_addr, mem_wdata, mem_rdata, write_data;
   logic        mem_req, mem_we, mem_ack, RegWrite, done, err;
   logic [3:0]  mem_be;

   mem_wb_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .valid(valid), .ready(ready), .funct3(funct3), .rd(rd),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite_in(RegWrite_in),
      .alu_result(alu_result), .rs2_data(rs2_data), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .RegWrite(RegWrite), .rd_out(rd_out), .write_data(write_data),
      .done(done), .err(err));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   int trig_cyc = 0;

   typedef struct { bit e; bit rw; logic [4:0] rd; logic [31:0] wd; } exp_t;
   typedef struct { logic [31:0] addr; bit we; logic [3:0] be; logic [31:0] wd;
                    logic [31:0] rdata; int dly; bit noack; bit abort; } mreq_t;
   exp_t  sbq[$];
   mreq_t mq[$];
   exp_t  mx;
   mreq_t mm;
   int    rn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every retire/error event pops one expected result
   initial forever begin
      @(negedge clk);
      if (rst && (done || err || RegWrite)) begin
         if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: done=%0b err=%0b RegWrite=%0b expected none", done, err, RegWrite);
         end else begin
            mx = sbq.pop_front();
            chk("event_cycle", cyc, trig_cyc + 1);
            chk("err", err, mx.e);
            chk("done", done, !mx.e);
            chk("RegWrite", RegWrite, mx.rw);
            if (mx.rw) begin
               chk("rd_out", rd_out, mx.rd);
               chk("write_data", write_data, mx.wd);
            end
         end
      end
   end

   // memory responder: checks each request against the expected access
   initial begin
      mem_ack = 0; mem_rdata = 0;
      forever begin
         @(negedge clk);
         if (rst && mem_req) begin
            if (mq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_mem_req: addr %h expected no request", mem_addr);
               rn = 0;
               while (mem_req && rn < 100) begin @(negedge clk); rn++; end
            end else begin
               mm = mq.pop_front();
               chk("req_cycle", cyc, trig_cyc + 1);
               chk("mem_addr", mem_addr, mm.addr);
               chk("mem_we", mem_we, mm.we);
               chk("mem_be", mem_be, mm.be);
               if (mm.we) chk("mem_wdata", mem_wdata, mm.wd);
               if (mm.abort) begin
                  rn = 0;
                  while (mem_req && rn < 100) begin @(negedge clk); rn++; end
               end else if (mm.noack) begin
                  rn = 1; trig_cyc = cyc;
                  while (rn < 100) begin
                     @(negedge clk);
                     if (!mem_req) break;
                     rn++; trig_cyc = cyc;
                  end
                  chk("timeout_len", rn, 16);
                  mem_ack = 1; mem_rdata = $urandom;   // late ack, must be ignored
                  @(negedge clk);
                  mem_ack = 0;
               end else begin
                  repeat (mm.dly) @(negedge clk);
                  chk("req_held_addr", mem_addr, mm.addr);
                  mem_ack = 1; mem_rdata = mm.rdata; trig_cyc = cyc;
                  @(negedge clk);
                  mem_ack = 0; mem_rdata = $urandom;
               end
            end
         end
      end
   end

   task automatic drive_junk();
      funct3 = 3'($urandom); rd = 5'($urandom); MemRead = 1'($urandom);
      MemWrite = 1'($urandom); RegWrite_in = 1'($urandom);
      alu_result = $urandom; rs2_data = $urandom;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [4:0] r, input bit mr, input bit mw,
                        input bit rwi, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] rdat, input int dly, input bit noack);
      bit mem = mr | mw;
      bit st  = mw;
      bit ld  = mr & !mw;
      int w   = st ? ((f3 == 0) ? 1 : (f3 == 1) ? 2 : 4)
                   : ((f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4);
      int a   = int'(alu % 4);
      bit mis = mem && (a % w != 0);
      exp_t  x;
      mreq_t m;
      logic [31:0] v;
      int k;
      x.e = mis; x.rw = 0; x.rd = r; x.wd = 0;
      if (!mem) begin
         x.rw = rwi && (r != 0); x.wd = alu;
      end else if (!mis) begin
         m.addr = alu & 32'hFFFF_FFFC; m.we = st;
         m.be = 4'(((1 << w) - 1) << a);
         m.wd = (w == 1) ? rs2[7:0] * 32'h0101_0101 : (w == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
         m.rdata = rdat; m.dly = dly; m.noack = noack; m.abort = 0;
         mq.push_back(m);
         if (noack) x.e = 1;
         else if (ld) begin
            v = rdat >> (8 * a);
            if (w == 1)      v = f3[2] ? 32'(v[7:0])  : 32'($signed(v[7:0]));
            else if (w == 2) v = f3[2] ? 32'(v[15:0]) : 32'($signed(v[15:0]));
            x.rw = rwi && (r != 0); x.wd = v;
         end
      end
      sbq.push_back(x);
      @(posedge clk); #1;
      valid = 1; funct3 = f3; rd = r; MemRead = mr; MemWrite = mw; RegWrite_in = rwi;
      alu_result = alu; rs2_data = rs2; trig_cyc = cyc;
      chk("ready_before", ready, 1);
      @(posedge clk); #1;
      valid = 0; drive_junk();
      k = 0;
      while (k < 60) begin
         @(negedge clk);
         if (done || err) break;
         k++;
      end
      if (k == 60) begin
         n_cmp++; n_bad++;
         $display("FAIL completion_timeout: no done/err within 60 cycles, expected one");
      end
      @(posedge clk); #1;
      chk("ready_after", ready, 1);
      repeat ($urandom % 3) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      valid = 0; drive_junk();
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_RegWrite", RegWrite, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_write_data", write_data, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1;

      issue(3'b000, 5'd5, 0, 0, 1, 32'h1234_5678, 32'h0, 32'h0, 0, 0);   // ALU op
      issue(3'b000, 5'd7, 1, 0, 1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 0); // LB
      issue(3'b100, 5'd7, 1, 0, 1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 0); // LBU
      issue(3'b101, 5'd8, 1, 0, 1, 32'h0000_0102, 32'h0, 32'h80FF_0000, 1, 0); // LHU
      issue(3'b001, 5'd9, 0, 1, 1, 32'h0000_0002, 32'h0000_ABCD, 32'h0, 2, 0); // SH
      issue(3'b010, 5'd3, 1, 0, 1, 32'h0000_0006, 32'h0, 32'h0, 0, 0);   // misaligned LW
      issue(3'b010, 5'd4, 1, 0, 1, 32'h0000_0200, 32'h0, 32'h0, 0, 1);   // LW timeout
      issue(3'b000, 5'd0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0);   // rd = x0
      issue(3'b010, 5'd6, 1, 1, 1, 32'h0000_0010, 32'h5555_AAAA, 32'h0, 1, 0); // both set

      // reset while a load is waiting on memory
      mm.addr = 32'h40; mm.we = 0; mm.be = 4'hF; mm.wd = 0; mm.rdata = 0;
      mm.dly = 0; mm.noack = 0; mm.abort = 1;
      mq.push_back(mm);
      @(posedge clk); #1;
      valid = 1; funct3 = 3'b010; rd = 5'd10; MemRead = 1; MemWrite = 0; RegWrite_in = 1;
      alu_result = 32'h40; trig_cyc = cyc;
      @(posedge clk); #1 valid = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      #1;
      chk("rst_mid_mem_req", mem_req, 0);
      chk("rst_mid_ready", ready, 1);
      chk("rst_mid_RegWrite", RegWrite, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      repeat (5) @(posedge clk);
      #1 chk("post_rst_ready", ready, 1);

      for (int i = 0; i < 200; i++) begin
         int kind = $urandom % 10;
         logic [31:0] alu = $urandom;
         if ($urandom % 2) alu[1:0] = 2'b00;
         issue(3'($urandom), ($urandom % 4 == 0) ? 5'd0 : 5'($urandom),
               (kind >= 3 && kind <= 5) || kind == 9, kind >= 6, 1'($urandom),
               alu, $urandom, $urandom, $urandom % 4, ($urandom % 25) == 0);
      end

      repeat (4) @(posedge clk);
      chk("sb_drained", sbq.size(), 0);
      chk("mq_drained", mq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Memory-access and write-back stage of the multi-cycle RISC-V core.
- Executes loads and stores against data memory through a req/ack handshake.
- Sign- or zero-extends load data.
- Drives the register-file write port with write_data, RegWrite and rd; this is the writer side feeding reg_and_imm.
- Non-memory instructions pass the ALU result straight through to write-back.

Parameters:
- TIMEOUT, 16: max cycles mem_req stays high without mem_ack before the access is aborted with err.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid  in  1  instruction presented; sampled only while ready=1.
- ready  out  1  unit idle and able to accept.
- funct3  in  3  load/store width and signedness.
- rd  in  5  destination register.
- MemRead  in  1  instruction is a load.
- MemWrite  in  1  instruction is a store.
- RegWrite_in  in  1  instruction writes rd.
- alu_result  in  32  effective address, or the result for non-memory ops.
- rs2_data  in  32  store data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  store data, lane-replicated.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle access completion.
- RegWrite  out  1  register-file write enable, one-cycle pulse.
- rd_out  out  5  register-file write address.
- write_data  out  32  register-file write data.
- done  out  1  one-cycle pulse when an instruction retires, whether by write-back or by store completion.
- err  out  1  one-cycle pulse on a misaligned access or timeout.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0.
  - All outputs 0 except ready=1.
  - mem_req drops immediately, including in the middle of an access.
- States and transitions:
  - IDLE: ready=1. On valid:
    - MemRead or MemWrite with misaligned address → ERR. Misaligned means: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
    - Aligned MemRead or MemWrite → REQ.
    - Otherwise → WB.
  - REQ:
    - mem_req=1; mem_addr/mem_we/mem_be/mem_wdata held stable.
    - Counter increments each cycle.
    - mem_ack=1 with a load → capture mem_rdata and go to WB.
    - mem_ack=1 with a store → go to DONE.
    - Counter reaches TIMEOUT → ERR.
  - WB:
    - RegWrite = RegWrite_in & (rd≠0); x0 is never written.
    - rd_out and write_data are valid in the same cycle.
    - done=1, then → IDLE.
  - DONE: done=1, RegWrite=0, then → IDLE.
  - ERR: err=1, RegWrite=0, done=0, no memory request issued, then → IDLE.
- Latency, with valid accepted in cycle N:
  - Non-memory op: RegWrite in N+1.
  - Memory op: mem_req rises in N+1; with ack in cycle A, the load write-back or store done is in A+1.
- Byte enables and store data (a = addr[1:0]):
  - SB (funct3 000): be = 0001<<a; wdata = {4{rs2[7:0]}}.
  - SH (001): be = 0011<<a; wdata = {2{rs2[15:0]}}.
  - SW (010): be = 1111.
- Loads: select the byte or half at a.
  - LB (000) / LH (001): sign-extend.
  - LBU (100) / LHU (101): zero-extend.
  - LW (010): full word.
  - Any other funct3 with MemRead or MemWrite is treated as word width.
- Latching: all instruction fields are latched at acceptance; input changes while ready=0 are ignored.
- mem_ack outside REQ is ignored.
- valid arriving in the WB/DONE/ERR cycle is not accepted; it is accepted in the following IDLE cycle.
- MemRead and MemWrite both set → handled as a store, with no write-back.

Test Plan:
- ALU op, rd=5, alu_result=0x12345678 → RegWrite=1, rd_out=5, write_data=0x12345678 in cycle N+1; done=1; ready returns 1 in N+2.
- LB at address 0x103 with mem_rdata=0x80FF0000 (ack after 2 cycles) → mem_addr=0x100, write_data=0xFFFFFF80. Same access as LBU → 0x00000080. LHU at 0x102 → 0x000080FF.
- SH at address 0x2, rs2=0x0000ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD; after ack, done=1 with RegWrite=0.
- LW at address 0x6 → err pulse in N+1; mem_req never asserted; RegWrite=0.
- LW with mem_ack never asserted → mem_req held for TIMEOUT=16 cycles, then err=1 and mem_req=0. A late ack is ignored.
- ALU op with rd=0 and write_data 0xFFFFFFFF → RegWrite stays 0. rst pulled low while in REQ → mem_req=0 immediately; after release, ready=1 and no write occurs.
